// File: rtl/pal_loader.sv
// Palette loader: captures a 32-entry palette from the HPS ROM download (slot 0,
// bytes 0x18000-0x1801F) and serves registered 12-bit RGB lookups. Optional macro
// PAL_SHADOW_EN adds a shadow table and a 32-cycle COMMIT copy into the live table.
module pal_loader (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        pix_en,
  input  logic [4:0]  pix_idx,
  input  logic        blank,
  output logic [11:0] pal_rgb,
  output logic        pal_valid,
  output logic        pal_err,
  output logic        busy
);

  localparam int unsigned NUM_ENT = 32;
  localparam int unsigned EW      = 5;
  localparam int unsigned DW      = 8;
  localparam int unsigned RGBW    = 12;
  localparam int unsigned WINW    = 19;
  localparam logic [WINW-1:0] WIN_BASE = {16'h0180, 3'b000};

`ifdef PAL_SHADOW_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_COMMIT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} state_e;
`endif

  state_e               state_q, state_d;
  logic                 dl_q;
  logic [NUM_ENT-1:0]   mask_q, mask_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [RGBW-1:0]      rgb_q, rgb_d;
  logic [DW-1:0]        live_q [NUM_ENT];

`ifdef PAL_SHADOW_EN
  logic [DW-1:0]        shadow_q [NUM_ENT];
  logic [EW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 commit_done;
`endif

  logic                 dl_rise, dl_fall, sel_rom, cap, mask_full, enter_load, show;
  logic [EW-1:0]        cap_ent;
  logic [DW-1:0]        ent;
  logic                 addr_unused;

  assign addr_unused = ioctl_addr[24];
  assign dl_rise     = ioctl_download & ~dl_q;
  assign dl_fall     = ~ioctl_download & dl_q;
  assign sel_rom     = (ioctl_index == 8'd0);
  assign cap_ent     = ioctl_addr[EW-1:0];
  assign cap         = (state_q == ST_LOAD) && sel_rom && ioctl_download && ioctl_wr &&
                       (ioctl_addr[23:5] == WIN_BASE);
  assign mask_full   = &mask_q;
  assign enter_load  = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  assign ent         = live_q[pix_idx];

`ifdef PAL_SHADOW_EN
  assign commit_done = (state_q == ST_COMMIT) && (cnt_q == EW'(NUM_ENT - 1));
  assign show        = !blank && valid_q && (state_q != ST_COMMIT);
`else
  assign show        = !blank && valid_q;
`endif

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a download raised during COMMIT resumes as LOAD afterwards
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dl_rise && sel_rom) state_d = ST_LOAD;
`ifdef PAL_SHADOW_EN
      ST_LOAD: if (dl_fall) state_d = mask_full ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: if (commit_done) state_d = (pend_q && ioctl_download) ? ST_LOAD : ST_IDLE;
`else
      ST_LOAD: if (dl_fall) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    mask_d  = mask_q;
    valid_d = valid_q;
    err_d   = err_q;
    busy_d  = (state_d != ST_IDLE);
    rgb_d   = rgb_q;
`ifdef PAL_SHADOW_EN
    cnt_d   = cnt_q;
    pend_d  = pend_q;
`endif

    if (enter_load)
      mask_d = '0;
    else if (cap)
      mask_d = mask_q | (NUM_ENT'(1) << cap_ent);

`ifdef PAL_SHADOW_EN
    if (state_q == ST_LOAD && dl_fall && !mask_full)
      err_d = 1'b1;
    if (state_q == ST_COMMIT) begin
      cnt_d = cnt_q + EW'(1);
      if (dl_rise && sel_rom) pend_d = 1'b1;
      else if (dl_fall)       pend_d = 1'b0;
      if (commit_done) begin
        valid_d = 1'b1;
        err_d   = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = '0;
      end
    end
`else
    if (enter_load)
      valid_d = 1'b0;
    if (state_q == ST_LOAD && dl_fall) begin
      valid_d = mask_full;
      err_d   = !mask_full;
    end
`endif

    if (pix_en)
      rgb_d = show ? {ent[7:6], ent[1:0], ent[5:4], ent[1:0], ent[3:2], ent[1:0]}
                   : RGBW'(0);
  end

  // Control and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q    <= 1'b0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rgb_q   <= '0;
`ifdef PAL_SHADOW_EN
      cnt_q   <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      dl_q    <= ioctl_download;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rgb_q   <= rgb_d;
`ifdef PAL_SHADOW_EN
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
`endif
    end
  end

  // Table storage, intentionally not reset
  always_ff @(posedge clk_sys) begin
`ifdef PAL_SHADOW_EN
    if (cap)
      shadow_q[cap_ent] <= ioctl_dout;
    if (state_q == ST_COMMIT)
      live_q[cnt_q] <= shadow_q[cnt_q];
`else
    if (cap)
      live_q[cap_ent] <= ioctl_dout;
`endif
  end

  assign pal_rgb   = rgb_q;
  assign pal_valid = valid_q;
  assign pal_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pal_loader.sv
// Scoreboard bench for pal_loader; expectations follow PAL_SHADOW_EN when defined.
module tb_pal_loader;

`ifdef PAL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        pix_en;
  logic [4:0]  pix_idx;
  logic        blank;
  logic [11:0] pal_rgb;
  logic        pal_valid;
  logic        pal_err;
  logic        busy;

  pal_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .pix_en(pix_en), .pix_idx(pix_idx), .blank(blank),
    .pal_rgb(pal_rgb), .pal_valid(pal_valid), .pal_err(pal_err), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_live [32];
  logic [7:0]  m_rx   [32];
  logic [31:0] m_mask;
  bit          m_valid, m_err;
  logic [11:0] exp_q [$];
  logic [11:0] last_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_of(input logic [7:0] e);
    return {e[7:6], e[1:0], e[5:4], e[1:0], e[3:2], e[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pix(input logic [4:0] idx, input bit blk);
    logic [11:0] e;
    pix_idx = idx;
    blank   = blk;
    pix_en  = 1'b1;
    exp_q.push_back((blk || !m_valid) ? 12'h000 : rgb_of(m_live[idx]));
    tick();
    pix_en = 1'b0;
    blank  = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    check($sformatf("rgb[%0d]", idx), 32'(pal_rgb), 32'(e));
  endtask

  task automatic wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (idx == 8'd0 && addr[23:5] == 19'h00C00) begin
      m_rx[addr[4:0]]   = d;
      m_mask[addr[4:0]] = 1'b1;
      if (!SHADOW) m_live[addr[4:0]] = d;
    end
    tick();
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    check("valid_dl", 32'(pal_valid), 32'(m_valid));
  endtask

  task automatic dl_begin();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    m_mask         = '0;
    if (!SHADOW) m_valid = 1'b0;
    tick();
    tick();
    check("busy_load", 32'(busy), 32'd1);
  endtask

  task automatic dl_end();
    int n;
    bit full;
    full = &m_mask;
    ioctl_download = 1'b0;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check("busy_len", 32'(n), (full && SHADOW) ? 32'd32 : 32'd0);
    if (full) begin
      m_live  = m_rx;
      m_valid = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
      if (!SHADOW) m_valid = 1'b0;
    end
    check("valid", 32'(pal_valid), 32'(m_valid));
    check("err", 32'(pal_err), 32'(m_err));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_rgb", 32'(pal_rgb), 32'd0);
    check("rst_valid", 32'(pal_valid), 32'd0);
    check("rst_err", 32'(pal_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    m_valid        = 1'b0;
    m_err          = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(pal_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; pix_en = 1'b0; pix_idx = '0; blank = 1'b0;
    m_mask = '0; m_valid = 1'b0; m_err = 1'b0; last_exp = '0;
    for (int i = 0; i < 32; i++) begin m_live[i] = '0; m_rx[i] = '0; end
    repeat (3) @(posedge clk_sys);
    #1;
    check("init_rgb", 32'(pal_rgb), 32'd0);
    check("init_valid", 32'(pal_valid), 32'd0);
    check("init_err", 32'(pal_err), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // download on another slot must not start a load
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    tick();
    check("slot1_busy", 32'(busy), 32'd0);
    wr(8'd1, 25'h18000, 8'h77);
    ioctl_download = 1'b0;
    tick();
    check("slot1_err", 32'(pal_err), 32'd0);

    // full ramp download
    dl_begin();
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), 8'(i));
    dl_end();
    pix(5'd5, 1'b0);
    for (int k = 0; k < 8; k++) pix(5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));

    // no pix_en: output holds
    pix_idx = 5'd31;
    tick();
    check("hold", 32'(pal_rgb), 32'(last_exp));

    // incomplete download, entry 7 missing; out-of-window writes must not fill it
    dl_begin();
    for (int i = 0; i < 32; i++) if (i != 7) wr(8'd0, 25'h18000 + 25'(i), 8'h80 | 8'(i));
    wr(8'd1, 25'h18007, 8'h11);
    wr(8'd0, 25'h18027, 8'h22);
    pix(5'd2, 1'b0);
    dl_end();
    pix(5'd7, 1'b0);
    pix(5'd2, 1'b0);
    pix(5'd5, 1'b0);

    // full download, entry 3 = FF, entry 10 overwritten, aliases ignored
    dl_begin();
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), (i == 3) ? 8'hFF : 8'(i * 37));
    wr(8'd0, 25'h1800A, 8'hA5);
    wr(8'd0, 25'h18020, 8'h3C);
    wr(8'd1, 25'h18001, 8'h3C);
    dl_end();
    pix(5'd3, 1'b1);
    pix(5'd3, 1'b0);
    check("rgb_fff", 32'(pal_rgb), 32'h0000_0FFF);
    pix(5'd0, 1'b0);
    pix(5'd1, 1'b0);
    pix(5'd10, 1'b0);

`ifdef PAL_SHADOW_EN
    // download raised during COMMIT is deferred, then runs as a normal load
    dl_begin();
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), 8'h40 + 8'(i));
    ioctl_download = 1'b0;
    tick();
    repeat (3) tick();
    pix_idx = 5'd9;
    pix_en  = 1'b1;
    tick();
    pix_en = 1'b0;
    check("rgb_commit", 32'(pal_rgb), 32'd0);
    ioctl_download = 1'b1;
    repeat (28) tick();
    check("defer_busy", 32'(busy), 32'd1);
    check("defer_valid", 32'(pal_valid), 32'd1);
    m_live  = m_rx;
    m_valid = 1'b1;
    m_mask  = '0;
    pix(5'd9, 1'b0);
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), 8'h33 ^ 8'(i));
    pix(5'd9, 1'b0);
    dl_end();
    pix(5'd9, 1'b0);

    // reset in the middle of COMMIT
    dl_begin();
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), 8'h5A ^ 8'(i));
    ioctl_download = 1'b0;
    tick();
    repeat (10) tick();
    do_reset();
`else
    // reset in the middle of LOAD
    dl_begin();
    for (int i = 0; i < 10; i++) wr(8'd0, 25'h18000 + 25'(i), 8'h5A ^ 8'(i));
    do_reset();
    for (int i = 0; i < 10; i++) m_live[i] = 8'h5A ^ 8'(i);
`endif
    pix(5'd5, 1'b0);

    // recovery download
    dl_begin();
    for (int i = 0; i < 32; i++) wr(8'd0, 25'h18000 + 25'(i), ~8'(i));
    dl_end();
    for (int k = 0; k < 4; k++) pix(5'($urandom_range(0, 31)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
